// File: rtl/stripe_pkg.sv
// Shared symbol constants, lane count and FSM state encoding for the
// byte striper.
package stripe_pkg;

  localparam int LANES = 4;

  // PCIe K-symbols as seen on the 8-bit byte stream
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] FTS = 8'h3C;
  localparam logic [7:0] IDL = 8'h7C;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/skp_timer.sv
// Idle-time counter that requests a SKP ordered-set insertion.
// Only instantiated when BYTE_STRIPING_SKP_EN is defined.
// o_insert is high for exactly one cycle after SKP_INTERVAL idle,
// non-accepting cycles; the count restarts after the insertion cycle.
module skp_timer #(
  parameter int SKP_INTERVAL = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_idle,
  input  logic i_accept,
  output logic o_insert
);

  logic [7:0] r_cnt;
  logic       r_ins;

  // Count idle cycles; hold at zero outside IDLE or when a byte is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
      r_ins <= 1'b0;
    end else if (!i_idle) begin
      r_cnt <= 8'd0;
      r_ins <= 1'b0;
    end else if (r_ins) begin
      r_cnt <= 8'd0;
      r_ins <= 1'b0;
    end else if (i_accept) begin
      r_cnt <= 8'd0;
    end else if (r_cnt == 8'(SKP_INTERVAL - 1)) begin
      r_cnt <= 8'd0;
      r_ins <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_insert = r_ins;

endmodule

// File: rtl/byte_striping.sv
// TX byte striper: distributes a framed byte stream round-robin over
// four lanes. STP/SDP lands on lane 0, END/EDB on lane 3, short final
// symbols are PAD-filled, and all lanes carry IDL between packets.
// Optional SKP insertion is enabled with the BYTE_STRIPING_SKP_EN macro.
//
// state   | meaning
// IDLE    | waiting for STP/SDP; other bytes are dropped with err
// COLLECT | buffering bytes of the current symbol, r_c = next lane
module byte_striping
  import stripe_pkg::*;
#(
  parameter int SKP_INTERVAL = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fromMux,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] TL0,
  output logic [7:0] TL1,
  output logic [7:0] TL2,
  output logic [7:0] TL3,
  output logic       sym_valid,
  output logic       err
);

  if (SKP_INTERVAL < 4 || SKP_INTERVAL > 255) begin : g_bad_interval
    $error("byte_striping: SKP_INTERVAL out of range 4..255");
  end

  state_t     r_state, w_state_nxt;
  logic [1:0] r_c, w_c_nxt;
  logic [7:0] r_buf [3];
  logic [7:0] w_buf_nxt [3];
  logic [7:0] r_lane [LANES];
  logic [7:0] w_lane_nxt [LANES];
  logic       r_sym, w_sym_nxt;
  logic       r_err, w_err_nxt;
  logic       w_accept;
  logic       w_is_start;
  logic       w_is_end;
  logic       w_skp_insert;

`ifdef BYTE_STRIPING_SKP_EN
  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk      (clk),
    .reset    (reset),
    .i_idle   (r_state == IDLE),
    .i_accept (w_accept),
    .o_insert (w_skp_insert)
  );
  // The insertion cycle blocks input so the SKP set never splits a packet.
  assign in_ready = ~w_skp_insert;
`else
  assign w_skp_insert = 1'b0;
  assign in_ready     = 1'b1;
`endif

  assign w_accept   = in_valid && in_ready;
  assign w_is_start = (fromMux == STP) || (fromMux == SDP);
  assign w_is_end   = (fromMux == END) || (fromMux == EDB);

  // State, counter, buffers and registered lane outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_c     <= 2'd0;
      r_sym   <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < 3; i++) r_buf[i] <= IDL;
      for (int i = 0; i < LANES; i++) r_lane[i] <= IDL;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_sym   <= w_sym_nxt;
      r_err   <= w_err_nxt;
      for (int i = 0; i < 3; i++) r_buf[i] <= w_buf_nxt[i];
      for (int i = 0; i < LANES; i++) r_lane[i] <= w_lane_nxt[i];
    end
  end

  // Next-state, buffer update and lane contents for the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_sym_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    for (int i = 0; i < 3; i++) w_buf_nxt[i] = r_buf[i];
    for (int i = 0; i < LANES; i++) w_lane_nxt[i] = IDL;

    if (w_skp_insert) begin
      w_lane_nxt[0] = COM;
      for (int i = 1; i < LANES; i++) w_lane_nxt[i] = SKP;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_start) begin
            w_buf_nxt[0] = fromMux;
            w_c_nxt      = 2'd1;
            w_state_nxt  = COLLECT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (w_accept) begin
          if (w_is_end) begin
            for (int i = 0; i < 3; i++)
              w_lane_nxt[i] = (2'(i) < r_c) ? r_buf[i] : PAD;
            w_lane_nxt[LANES-1] = fromMux;
            w_sym_nxt           = 1'b1;
            w_c_nxt             = 2'd0;
            w_state_nxt         = IDLE;
          end else begin
            // A framing start inside a packet is carried as data but flagged.
            w_err_nxt = w_is_start;
            if (r_c == 2'd3) begin
              for (int i = 0; i < 3; i++) w_lane_nxt[i] = r_buf[i];
              w_lane_nxt[LANES-1] = fromMux;
              w_sym_nxt           = 1'b1;
              w_c_nxt             = 2'd0;
            end else begin
              w_buf_nxt[r_c] = fromMux;
              w_c_nxt        = r_c + 2'd1;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign TL0       = r_lane[0];
  assign TL1       = r_lane[1];
  assign TL2       = r_lane[2];
  assign TL3       = r_lane[3];
  assign sym_valid = r_sym;
  assign err       = r_err;

endmodule

// File: doc/byte_striping.md
Name: byte_striping

Overview:
- TX-side PCIe byte striper: takes the single framed byte stream from the mux stage and distributes it round-robin across 4 lanes, TL0..TL3.
- Output lane format: framing start (STP/SDP) always on lane 0; END/EDB always on lane 3; short final symbols padded with PAD.
- Outside packets, all lanes carry IDL. Output is directly consumable by the RX-side unstriping stage over a lane loopback.

Parameters:
- LANES, 4, lane count; fixed at 4 (counter is 2 bits).
- SKP_INTERVAL, 16, idle cycles between SKP ordered-set insertions (optional feature only); legal range 4..255.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fromMux  input  8  input byte (K-symbol or data).
- in_valid  input  1  fromMux valid this cycle.
- in_ready  output  1  block accepts byte this cycle; byte transfers when in_valid && in_ready.
- TL0  output  8  lane 0 byte, registered.
- TL1  output  8  lane 1 byte, registered.
- TL2  output  8  lane 2 byte, registered.
- TL3  output  8  lane 3 byte, registered.
- sym_valid  output  1  TL0..TL3 hold a striped packet symbol this cycle.
- err  output  1  one-cycle pulse on framing violation.

Behaviour:
- Symbol constants: COM=BC, PAD=F7, SKP=1C, STP=FB, SDP=5C, END=FD, EDB=FE, FTS=3C, IDL=7C.
- Reset values (async): TL0..TL3=IDL, sym_valid=0, err=0, state=IDLE, c=0, lane buffers=IDL. in_ready=1.
- State machine: IDLE, COLLECT. 2-bit lane counter c; 3 lane buffers buf0..buf2.
- IDLE:
  - Accepted STP or SDP: buf0 <= byte, c <= 1, go to COLLECT.
  - Any other accepted byte: dropped; err pulses next cycle.
  - No accept: nothing stored.
- COLLECT, accepted byte b, with c < 3 and b not END/EDB: buf[c] <= b, c <= c+1.
- COLLECT, c == 3 and b not END/EDB: next cycle TL0..TL2 <= buf0..buf2, TL3 <= b, sym_valid <= 1; c <= 0; stay in COLLECT.
- COLLECT, b == END or EDB at any c:
  - Next cycle, lanes < c carry buffered bytes, lanes c..2 carry PAD, TL3 carries b; sym_valid <= 1.
  - c <= 0; go to IDLE.
  - END at c == 0 therefore emits PAD,PAD,PAD,END.
- COLLECT, accepted STP/SDP: treated as data byte; err pulses next cycle.
- Any cycle without emission: TL0..TL3 <= IDL, sym_valid <= 0. Lanes never hold a stale symbol.
- Latency: exactly 1 clk from the accepting edge of the last byte of a symbol to sym_valid. Throughput: 4 input bytes per symbol, with no bubbles.
- in_valid=0 in COLLECT: state held; lanes emit IDL (sym_valid=0) until the symbol completes.
- Reset mid-packet: partial bytes discarded; no END emitted; lanes go to IDL immediately.

Optional Feature:
- Macro: BYTE_STRIPING_SKP_EN.
- Defined:
  - A counter counts cycles spent in IDLE with no accept.
  - When it reaches SKP_INTERVAL-1, in_ready drops for 1 cycle; the next cycle emits COM on TL0 and SKP on TL1..TL3 (sym_valid=0); the counter clears.
  - Leaving IDLE clears the counter. In COLLECT the counter is frozen at 0.
- Undefined: no counter; in_ready tied to 1.

Decomposition:
- Package stripe_pkg: the 9 K-symbol localparams, LANES, and the state encoding (IDLE=0, COLLECT=1).
- Sub-module skp_timer: idle counter plus insert strobe, instantiated only under BYTE_STRIPING_SKP_EN.
- Everything else stays in byte_striping.

Test Plan:
- Full symbols: FB,AA,BB,CC,DD,EE,11,22 back-to-back. Required: cycle after CC: TL=FB,AA,BB,CC, sym_valid=1. Cycle after 22: TL=DD,EE,11,22.
- Short tail: FB,AA,BB,CC,DD,FD. Required: second symbol TL=DD,F7,F7,FD, state returns to IDLE, then lanes 7C with sym_valid=0.
- END on boundary: 5C,01,02,03,FD. Required: 5C,01,02,03 then F7,F7,F7,FD. EDB in place of FD gives F7,F7,F7,FE.
- Gaps and garbage: in IDLE send 55 -> dropped, err pulse, lanes stay 7C. FB,AA with 2 idle in_valid=0 cycles, then BB,CC -> FB,AA,BB,CC, lanes 7C during the gap.
- Reset mid-packet: FB,AA, assert reset -> lanes 7C asynchronously. Then 5C,10,20,30 -> 5C,10,20,30; no leftover AA.
- With BYTE_STRIPING_SKP_EN, SKP_INTERVAL=4: idle stream -> in_ready low for 1 cycle every 5 cycles, and lanes BC,1C,1C,1C on the following cycle.
